// File: rtl/segment_write_arbiter_pkg.sv
// rtl/segment_write_arbiter_pkg.sv - shared encodings for the segment write arbiter
package segment_write_arbiter_pkg;

    localparam int SEG_SEL_W = 3;

    typedef enum logic [SEG_SEL_W-1:0] {
        SEG_ES = 3'd0,
        SEG_CS = 3'd1,
        SEG_SS = 3'd2,
        SEG_DS = 3'd3,
        SEG_FS = 3'd4,
        SEG_GS = 3'd5
    } seg_e;

    typedef enum logic {
        NORMAL   = 1'b0,
        FORCE_UC = 1'b1
    } arb_state_e;

    // Selects 6 and 7 name no segment register; they are accepted but never written.
    function automatic logic sel_is_valid(input logic [SEG_SEL_W-1:0] sel);
        return (sel <= SEG_GS);
    endfunction

endpackage

// File: rtl/segment_write_arbiter_if.sv
// rtl/segment_write_arbiter_if.sv - request, register-file and retire signals of the arbiter
interface segment_write_arbiter_if
    import segment_write_arbiter_pkg::*;
#(
    parameter int DATA_W = 16
);

    logic                 wb_valid;
    logic [SEG_SEL_W-1:0] wb_sel;
    logic [DATA_W-1:0]    wb_data;
    logic                 wb_ready;

    logic                 uc_valid;
    logic [SEG_SEL_W-1:0] uc_sel;
    logic [DATA_W-1:0]    uc_data;
    logic                 uc_ready;

    logic                 flush;

    logic                 seg_we;
    logic [SEG_SEL_W-1:0] seg_sel;
    logic [DATA_W-1:0]    seg_data;

    logic                 retire_valid;
    logic [SEG_SEL_W-1:0] retire_sel;

    logic                 bad_sel_err;

    // Requester side: writeback stage, microcode sequencer and pipeline control.
    modport master (
        output wb_valid, wb_sel, wb_data,
        input  wb_ready,
        output uc_valid, uc_sel, uc_data,
        input  uc_ready,
        output flush,
        input  seg_we, seg_sel, seg_data,
        input  retire_valid, retire_sel,
        input  bad_sel_err
    );

    // Arbiter side.
    modport slave (
        input  wb_valid, wb_sel, wb_data,
        output wb_ready,
        input  uc_valid, uc_sel, uc_data,
        output uc_ready,
        input  flush,
        output seg_we, seg_sel, seg_data,
        output retire_valid, retire_sel,
        output bad_sel_err
    );

endinterface

// File: rtl/segment_write_arbiter_starve_ctr.sv
// rtl/segment_write_arbiter_starve_ctr.sv - 4-bit saturating UC starvation counter (seg_arb_starve_ctr)
module seg_arb_starve_ctr #(
    parameter int LIMIT = 4
) (
    input  logic clk,
    input  logic reset,
    input  logic clear,
    input  logic inc,
    output logic at_limit
);

    localparam logic [3:0] LIMIT_M1 = 4'(LIMIT - 1);

    logic [3:0] count;

    // Clear wins over increment; the count sticks at 15 instead of wrapping.
    always_ff @(posedge clk) begin
        if (reset || clear) begin
            count <= 4'd0;
        end else if (inc && (count != 4'hF)) begin
            count <= count + 4'd1;
        end
    end

    // High when one more refusal brings the count to LIMIT.
    always_comb begin
        at_limit = (count >= LIMIT_M1);
    end

endmodule

// File: rtl/segment_write_arbiter.sv
// rtl/segment_write_arbiter.sv - WB/UC arbiter for the segment register-file write port; SEG_ARB_PERF_EN adds grant counters
module segment_write_arbiter
    import segment_write_arbiter_pkg::*;
#(
    parameter int STARVE_LIMIT = 4,
    parameter int DATA_W       = 16
) (
    input  logic                     clk,
    input  logic                     reset,
    segment_write_arbiter_if.slave   bus
`ifdef SEG_ARB_PERF_EN
    ,
    output logic [31:0]              wb_grant_cnt,
    output logic [31:0]              uc_grant_cnt,
    output logic [31:0]              force_cnt
`endif
);

    arb_state_e           state;
    arb_state_e           state_next;

    logic                 wb_grant;
    logic                 uc_grant;
    logic                 grant;
    logic [SEG_SEL_W-1:0] grant_sel;
    logic [DATA_W-1:0]    grant_data;

    logic                 ctr_clear;
    logic                 ctr_inc;
    logic                 ctr_at_limit;

    logic                 wr_q;
    logic [SEG_SEL_W-1:0] sel_q;
    logic [DATA_W-1:0]    data_q;
    logic                 err_q;

    seg_arb_starve_ctr #(
        .LIMIT (STARVE_LIMIT)
    ) u_starve_ctr (
        .clk      (clk),
        .reset    (reset),
        .clear    (ctr_clear),
        .inc      (ctr_inc),
        .at_limit (ctr_at_limit)
    );

    // Arbiter state register.
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= NORMAL;
        end else begin
            state <= state_next;
        end
    end

    // Grant selection, starvation bookkeeping and next state.
    always_comb begin
        state_next = state;
        wb_grant   = 1'b0;
        uc_grant   = 1'b0;
        ctr_clear  = 1'b0;
        ctr_inc    = 1'b0;
        if (reset) begin
            state_next = NORMAL;
        end else if (bus.flush) begin
            // Flush drops UC bookkeeping only; WB keeps flowing under plain priority.
            wb_grant   = bus.wb_valid;
            ctr_clear  = 1'b1;
            state_next = NORMAL;
        end else begin
            unique case (state)
                NORMAL: begin
                    wb_grant = bus.wb_valid;
                    uc_grant = bus.uc_valid && !bus.wb_valid;
                    if (uc_grant) begin
                        ctr_clear = 1'b1;
                    end else if (bus.uc_valid) begin
                        ctr_inc = 1'b1;
                        if (ctr_at_limit) begin
                            state_next = FORCE_UC;
                        end
                    end
                end
                FORCE_UC: begin
                    // Either UC takes its forced grant now or it withdrew; both end the episode.
                    uc_grant   = bus.uc_valid;
                    ctr_clear  = 1'b1;
                    state_next = NORMAL;
                end
                default: begin
                    state_next = NORMAL;
                end
            endcase
        end
    end

    // Mux the winning request onto the write-stage inputs.
    always_comb begin
        grant      = wb_grant || uc_grant;
        grant_sel  = wb_grant ? bus.wb_sel  : bus.uc_sel;
        grant_data = wb_grant ? bus.wb_data : bus.uc_data;
    end

    // Write stage: one cycle between acceptance and the register-file write.
    always_ff @(posedge clk) begin
        if (reset) begin
            wr_q   <= 1'b0;
            sel_q  <= '0;
            data_q <= '0;
            err_q  <= 1'b0;
        end else begin
            wr_q <= grant && sel_is_valid(grant_sel);
            if (grant) begin
                sel_q  <= grant_sel;
                data_q <= grant_data;
            end
            if (grant && !sel_is_valid(grant_sel)) begin
                err_q <= 1'b1;
            end
        end
    end

    // Outputs read as zero while reset is held, so a write registered just before reset never lands.
    always_comb begin
        bus.wb_ready     = wb_grant;
        bus.uc_ready     = uc_grant;
        bus.seg_we       = wr_q && !reset;
        bus.retire_valid = wr_q && !reset;
        bus.seg_sel      = reset ? '0 : sel_q;
        bus.retire_sel   = reset ? '0 : sel_q;
        bus.seg_data     = reset ? '0 : data_q;
        bus.bad_sel_err  = err_q && !reset;
    end

`ifdef SEG_ARB_PERF_EN
    // Free-running wrap-around performance counters.
    always_ff @(posedge clk) begin
        if (reset) begin
            wb_grant_cnt <= 32'd0;
            uc_grant_cnt <= 32'd0;
            force_cnt    <= 32'd0;
        end else begin
            if (wb_grant) begin
                wb_grant_cnt <= wb_grant_cnt + 32'd1;
            end
            if (uc_grant) begin
                uc_grant_cnt <= uc_grant_cnt + 32'd1;
            end
            if ((state == NORMAL) && (state_next == FORCE_UC)) begin
                force_cnt <= force_cnt + 32'd1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_segment_write_arbiter.sv
// tb/tb_segment_write_arbiter.sv - self-checking bench for segment_write_arbiter
module tb_segment_write_arbiter;
    import segment_write_arbiter_pkg::*;

    localparam int LIMIT = 4;
    localparam int DW    = 16;

    logic clk = 1'b0;
    logic reset;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    segment_write_arbiter_if #(.DATA_W(DW)) bus ();

`ifdef SEG_ARB_PERF_EN
    logic [31:0] wb_grant_cnt, uc_grant_cnt, force_cnt;
`endif

    segment_write_arbiter #(
        .STARVE_LIMIT (LIMIT),
        .DATA_W       (DW)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .bus          (bus)
`ifdef SEG_ARB_PERF_EN
        ,
        .wb_grant_cnt (wb_grant_cnt),
        .uc_grant_cnt (uc_grant_cnt),
        .force_cnt    (force_cnt)
`endif
    );

    task automatic idle_inputs();
        bus.wb_valid = 1'b0;
        bus.wb_sel   = 3'd0;
        bus.wb_data  = '0;
        bus.uc_valid = 1'b0;
        bus.uc_sel   = 3'd0;
        bus.uc_data  = '0;
        bus.flush    = 1'b0;
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic flush_pulse();
        idle_inputs();
        bus.flush = 1'b1;
        next_cycle();
        bus.flush = 1'b0;
    endtask

    task automatic test_reset();
        idle_inputs();
        reset        = 1'b1;
        bus.wb_valid = 1'b1;
        bus.wb_sel   = 3'd2;
        bus.wb_data  = 16'h1234;
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            total++;
            if ({bus.seg_we, bus.retire_valid, bus.bad_sel_err, bus.wb_ready, bus.uc_ready,
                 bus.seg_sel, bus.retire_sel, bus.seg_data} !== '0) begin
                bad++;
                $display("FAIL reset_outputs_zero we=%b rv=%b err=%b wbr=%b ucr=%b sel=%0d data=%h exp=all zero",
                         bus.seg_we, bus.retire_valid, bus.bad_sel_err, bus.wb_ready, bus.uc_ready,
                         bus.seg_sel, bus.seg_data);
            end
            next_cycle();
        end
        reset = 1'b0;
        @(negedge clk);
        total++;
        if (bus.wb_ready !== 1'b1 || bus.uc_ready !== 1'b0) begin
            bad++;
            $display("FAIL reset_release_ready wbr=%b ucr=%b exp=1/0", bus.wb_ready, bus.uc_ready);
        end
        next_cycle();
        bus.wb_valid = 1'b0;
        @(negedge clk);
        total++;
        if (bus.seg_we !== 1'b1 || bus.seg_sel !== 3'd2 || bus.seg_data !== 16'h1234 ||
            bus.retire_valid !== 1'b1 || bus.retire_sel !== 3'd2) begin
            bad++;
            $display("FAIL reset_first_write we=%b sel=%0d data=%h rv=%b rsel=%0d exp=1/2/1234/1/2",
                     bus.seg_we, bus.seg_sel, bus.seg_data, bus.retire_valid, bus.retire_sel);
        end
        next_cycle();
    endtask

    task automatic test_starvation();
        bit exp_wb[6] = '{1, 1, 1, 1, 0, 1};
        idle_inputs();
        bus.wb_valid = 1'b1;
        bus.wb_sel   = 3'd3;
        bus.wb_data  = 16'hAAAA;
        bus.uc_valid = 1'b1;
        bus.uc_sel   = 3'd1;
        bus.uc_data  = 16'hF000;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            total++;
            if (bus.wb_ready !== exp_wb[i] || bus.uc_ready !== !exp_wb[i]) begin
                bad++;
                $display("FAIL starve_grant cyc=%0d wbr=%b ucr=%b exp=%b/%b",
                         i, bus.wb_ready, bus.uc_ready, exp_wb[i], !exp_wb[i]);
            end
            if (i == 5) begin
                total++;
                if (bus.seg_we !== 1'b1 || bus.seg_sel !== 3'd1 || bus.seg_data !== 16'hF000) begin
                    bad++;
                    $display("FAIL starve_uc_write we=%b sel=%0d data=%h exp=1/1/f000",
                             bus.seg_we, bus.seg_sel, bus.seg_data);
                end
            end
            next_cycle();
        end
        flush_pulse();
    endtask

    task automatic test_back_to_back();
        logic [2:0]  sels[3]  = '{3'd2, 3'd3, 3'd5};
        logic [15:0] datas[3] = '{16'h0102, 16'h0304, 16'h0506};
        idle_inputs();
        for (int i = 0; i < 4; i++) begin
            if (i < 3) begin
                bus.wb_valid = 1'b1;
                bus.wb_sel   = sels[i];
                bus.wb_data  = datas[i];
            end else begin
                bus.wb_valid = 1'b0;
            end
            @(negedge clk);
            if (i > 0) begin
                total++;
                if (bus.seg_we !== 1'b1 || bus.seg_sel !== sels[i-1] || bus.seg_data !== datas[i-1] ||
                    bus.retire_valid !== 1'b1 || bus.retire_sel !== sels[i-1]) begin
                    bad++;
                    $display("FAIL b2b_write idx=%0d we=%b sel=%0d data=%h rv=%b rsel=%0d exp sel=%0d data=%h",
                             i - 1, bus.seg_we, bus.seg_sel, bus.seg_data, bus.retire_valid,
                             bus.retire_sel, sels[i-1], datas[i-1]);
                end
            end
            next_cycle();
        end
    endtask

    task automatic test_flush_force();
        bit exp_wb[5] = '{1, 1, 1, 1, 0};
        idle_inputs();
        bus.wb_valid = 1'b1;
        bus.wb_sel   = 3'd4;
        bus.wb_data  = 16'h4444;
        bus.uc_valid = 1'b1;
        bus.uc_sel   = 3'd0;
        bus.uc_data  = 16'h1111;
        repeat (LIMIT) next_cycle();
        bus.wb_valid = 1'b0;
        bus.flush    = 1'b1;
        @(negedge clk);
        total++;
        if (bus.uc_ready !== 1'b0 || bus.wb_ready !== 1'b0) begin
            bad++;
            $display("FAIL flush_force_ready ucr=%b wbr=%b exp=0/0", bus.uc_ready, bus.wb_ready);
        end
        next_cycle();
        bus.flush    = 1'b0;
        bus.wb_valid = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            if (i == 0) begin
                total++;
                if (bus.seg_we !== 1'b0 || bus.retire_valid !== 1'b0) begin
                    bad++;
                    $display("FAIL flush_no_uc_write we=%b rv=%b exp=0/0", bus.seg_we, bus.retire_valid);
                end
            end
            total++;
            if (bus.wb_ready !== exp_wb[i] || bus.uc_ready !== !exp_wb[i]) begin
                bad++;
                $display("FAIL flush_then_normal cyc=%0d wbr=%b ucr=%b exp=%b/%b",
                         i, bus.wb_ready, bus.uc_ready, exp_wb[i], !exp_wb[i]);
            end
            next_cycle();
        end
        flush_pulse();
    endtask

    task automatic test_bad_sel();
        idle_inputs();
        bus.wb_valid = 1'b1;
        bus.wb_sel   = 3'd7;
        bus.wb_data  = 16'hBEEF;
        @(negedge clk);
        total++;
        if (bus.wb_ready !== 1'b1 || bus.bad_sel_err !== 1'b0) begin
            bad++;
            $display("FAIL badsel_accept wbr=%b err=%b exp=1/0", bus.wb_ready, bus.bad_sel_err);
        end
        next_cycle();
        bus.wb_sel  = 3'd1;
        bus.wb_data = 16'h0001;
        @(negedge clk);
        total++;
        if (bus.seg_we !== 1'b0 || bus.retire_valid !== 1'b0 || bus.bad_sel_err !== 1'b1) begin
            bad++;
            $display("FAIL badsel_no_write we=%b rv=%b err=%b exp=0/0/1",
                     bus.seg_we, bus.retire_valid, bus.bad_sel_err);
        end
        next_cycle();
        bus.wb_valid = 1'b0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            total++;
            if (bus.bad_sel_err !== 1'b1) begin
                bad++;
                $display("FAIL badsel_sticky cyc=%0d err=%b exp=1", i, bus.bad_sel_err);
            end
            next_cycle();
        end
        reset = 1'b1;
        next_cycle();
        reset = 1'b0;
        @(negedge clk);
        total++;
        if (bus.bad_sel_err !== 1'b0) begin
            bad++;
            $display("FAIL badsel_reset_clear err=%b exp=0", bus.bad_sel_err);
        end
        next_cycle();
    endtask

    task automatic test_reset_mid();
        idle_inputs();
        bus.wb_valid = 1'b1;
        bus.wb_sel   = 3'd5;
        bus.wb_data  = 16'h5555;
        @(negedge clk);
        total++;
        if (bus.wb_ready !== 1'b1) begin
            bad++;
            $display("FAIL rstmid_grant wbr=%b exp=1", bus.wb_ready);
        end
        next_cycle();
        reset        = 1'b1;
        bus.wb_valid = 1'b0;
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            total++;
            if (bus.seg_we !== 1'b0 || bus.retire_valid !== 1'b0) begin
                bad++;
                $display("FAIL rstmid_discard cyc=%0d we=%b rv=%b exp=0/0", i, bus.seg_we, bus.retire_valid);
            end
            next_cycle();
            reset = 1'b0;
        end
    endtask

    task automatic test_random();
        int         refused = 0;
        bit         forced  = 0;
        bit         err     = 0;
        bit         p_valid = 0;
        logic [2:0] p_sel   = 0;
        logic [15:0] p_data = 0;
        bit         wb_hold = 0;
        bit         uc_hold = 0;
        bit         e_wb, e_uc, g;
        idle_inputs();
        reset = 1'b1;
        repeat (2) next_cycle();
        reset = 1'b0;
        for (int cyc = 0; cyc < 500; cyc++) begin
            if (!wb_hold) begin
                bus.wb_valid = ($urandom_range(0, 3) != 0);
                bus.wb_sel   = ($urandom_range(0, 9) == 0) ? 3'($urandom_range(6, 7)) : 3'($urandom_range(0, 5));
                bus.wb_data  = 16'($urandom);
            end
            if (!uc_hold) begin
                bus.uc_valid = ($urandom_range(0, 1) != 0);
                bus.uc_sel   = ($urandom_range(0, 9) == 0) ? 3'($urandom_range(6, 7)) : 3'($urandom_range(0, 5));
                bus.uc_data  = 16'($urandom);
            end
            bus.flush = ($urandom_range(0, 15) == 0);

            if (forced && !bus.flush) begin
                e_wb = 1'b0;
                e_uc = bus.uc_valid;
            end else begin
                e_wb = bus.wb_valid;
                e_uc = bus.uc_valid && !bus.wb_valid && !bus.flush;
            end

            @(negedge clk);
            total++;
            if (bus.wb_ready !== e_wb || bus.uc_ready !== e_uc) begin
                bad++;
                $display("FAIL rnd_ready cyc=%0d wbr=%b ucr=%b exp=%b/%b", cyc, bus.wb_ready, bus.uc_ready, e_wb, e_uc);
            end
            total++;
            if (bus.seg_we !== (p_valid && p_sel <= 3'd5) || bus.retire_valid !== (p_valid && p_sel <= 3'd5)) begin
                bad++;
                $display("FAIL rnd_we cyc=%0d we=%b rv=%b exp=%b", cyc, bus.seg_we, bus.retire_valid, p_valid && p_sel <= 3'd5);
            end
            if (p_valid && p_sel <= 3'd5) begin
                total++;
                if (bus.seg_sel !== p_sel || bus.retire_sel !== p_sel || bus.seg_data !== p_data) begin
                    bad++;
                    $display("FAIL rnd_wdata cyc=%0d sel=%0d rsel=%0d data=%h exp=%0d/%h",
                             cyc, bus.seg_sel, bus.retire_sel, bus.seg_data, p_sel, p_data);
                end
            end
            total++;
            if (bus.bad_sel_err !== err) begin
                bad++;
                $display("FAIL rnd_err cyc=%0d err=%b exp=%b", cyc, bus.bad_sel_err, err);
            end

            g       = e_wb || e_uc;
            p_valid = g;
            p_sel   = e_wb ? bus.wb_sel : bus.uc_sel;
            p_data  = e_wb ? bus.wb_data : bus.uc_data;
            if (g && p_sel > 3'd5) err = 1'b1;
            if (bus.flush || forced) begin
                refused = 0;
                forced  = 0;
            end else if (e_uc) begin
                refused = 0;
            end else if (bus.uc_valid) begin
                if (refused < 15) refused++;
                if (refused >= LIMIT) forced = 1;
            end
            wb_hold = bus.wb_valid && !e_wb;
            uc_hold = bus.uc_valid && !e_uc;
            next_cycle();
        end
        idle_inputs();
    endtask

    initial begin
        idle_inputs();
        reset = 1'b1;
        next_cycle();
        test_reset();
        test_starvation();
        test_back_to_back();
        test_flush_force();
        test_bad_sel();
        test_reset_mid();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
